// File: rtl/stack_cmd_ctrl.sv
// Command controller for two external 8-bit stacks: accepts one command, strobes the stacks, returns one response.
// Latency: accept edge -> EXEC (1 cycle) -> RESP; cmd_ready only in IDLE, RESP holds until rsp_ready.
module stack_cmd_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       cmd_sel,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       stk_select,
    output logic       stk_push,
    output logic       stk_pop,
    output logic [7:0] stk_data_in,
    input  logic [7:0] stk_rd_data,
    input  logic [1:0] stk_empty,
    input  logic [1:0] stk_full,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_PEEK = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic       sel_q, sel_d;
    logic [7:0] data_q, data_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_err_q, rsp_err_d;
    logic [7:0] err_count_q, err_count_d;

    logic       is_read;
    logic       exec_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NOP;
            sel_q       <= 1'b0;
            data_q      <= 8'h00;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Refusal is decided from the flags of the latched target stack during EXEC.
    always_comb begin
        is_read  = (op_q == OP_POP) || (op_q == OP_PEEK);
        exec_err = ((op_q == OP_PUSH) && stk_full[sel_q]) ||
                   (is_read && stk_empty[sel_q]);
    end

    always_comb begin
        op_d        = op_q;
        sel_d       = sel_q;
        data_d      = data_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        err_count_d = err_count_q;
        if ((state_q == S_IDLE) && cmd_valid) begin
            op_d   = cmd_op;
            sel_d  = cmd_sel;
            data_d = cmd_data;
        end
        if (state_q == S_EXEC) begin
            rsp_err_d  = exec_err;
            rsp_data_d = (is_read && !exec_err) ? stk_rd_data : 8'h00;
            if (exec_err && (err_count_q != 8'hFF)) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    always_comb begin
        cmd_ready   = (state_q == S_IDLE);
        rsp_valid   = (state_q == S_RESP);
        rsp_data    = rsp_data_q;
        rsp_err     = rsp_err_q;
        err_count   = err_count_q;
        stk_select  = sel_q;
        stk_push    = (state_q == S_EXEC) && (op_q == OP_PUSH) && !stk_full[sel_q];
        stk_pop     = (state_q == S_EXEC) && (op_q == OP_POP) && !stk_empty[sel_q];
        stk_data_in = (state_q == S_EXEC) ? data_q : 8'h00;
    end

endmodule

// File: tb/tb_stack_cmd_ctrl.sv
// Bench for stack_cmd_ctrl: two 16-deep stacks around the DUT, queue-based command model, per-cycle compare.
module tb_stack_cmd_ctrl;

    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] PUSH = 2'b01;
    localparam logic [1:0] POP  = 2'b10;
    localparam logic [1:0] PEEK = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_sel;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_data;
    logic       stk_select, stk_push, stk_pop;
    logic [7:0] stk_data_in, stk_rd_data;
    logic [1:0] stk_empty, stk_full;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    stack_cmd_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_sel(cmd_sel), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .stk_select(stk_select), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_data_in(stk_data_in), .stk_rd_data(stk_rd_data),
        .stk_empty(stk_empty), .stk_full(stk_full), .err_count(err_count)
    );

    // Two external stacks, 16 deep, sharing rst_n; deselected stack drives 0 onto the OR bus.
    logic [7:0] smem [2][16];
    logic [4:0] scnt [2];
    logic [3:0] top_idx;
    int push_cycles = 0;
    int pop_cycles  = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            scnt[0] <= 5'd0;
            scnt[1] <= 5'd0;
        end else begin
            if (stk_push) push_cycles <= push_cycles + 1;
            if (stk_pop)  pop_cycles  <= pop_cycles + 1;
            if (stk_push && scnt[stk_select] < 5'd16) begin
                smem[stk_select][scnt[stk_select][3:0]] <= stk_data_in;
                scnt[stk_select] <= scnt[stk_select] + 5'd1;
            end else if (stk_pop && scnt[stk_select] != 5'd0) begin
                scnt[stk_select] <= scnt[stk_select] - 5'd1;
            end
        end
    end

    always_comb begin
        top_idx     = 4'(scnt[stk_select] - 5'd1);
        stk_rd_data = (scnt[stk_select] != 5'd0) ? smem[stk_select][top_idx] : 8'h00;
        stk_empty   = {scnt[1] == 5'd0,  scnt[0] == 5'd0};
        stk_full    = {scnt[1] == 5'd16, scnt[0] == 5'd16};
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Behavioural model: plain LIFO queues and an expectation per accepted command.
    typedef struct {
        logic       push;
        logic       pop;
        logic       sel;
        logic [7:0] data;
        logic       err;
        logic [7:0] rdata;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_s0[$];
    logic [7:0] ref_s1[$];
    logic [7:0] ref_err = 8'h00;

    function automatic void predict(input logic [1:0] op, input logic sel, input logic [7:0] data);
        exp_t e;
        int   sz;
        e.push = 1'b0; e.pop = 1'b0; e.sel = sel; e.data = data;
        e.err = 1'b0; e.rdata = 8'h00;
        sz = sel ? ref_s1.size() : ref_s0.size();
        case (op)
            PUSH: if (sz == 16) e.err = 1'b1;
                  else begin
                      e.push = 1'b1;
                      if (sel) ref_s1.push_back(data); else ref_s0.push_back(data);
                  end
            POP:  if (sz == 0) e.err = 1'b1;
                  else begin
                      e.pop = 1'b1;
                      e.rdata = sel ? ref_s1.pop_back() : ref_s0.pop_back();
                  end
            PEEK: if (sz == 0) e.err = 1'b1;
                  else e.rdata = sel ? ref_s1[sz-1] : ref_s0[sz-1];
            default: ;
        endcase
        if (e.err && ref_err != 8'hFF) ref_err = ref_err + 8'd1;
        e.cnt = ref_err;
        exp_q.push_back(e);
    endfunction

    // Per-cycle compare against the model, sampled on the falling edge.
    logic       in_exec   = 1'b0;
    logic       prev_hold = 1'b0;
    logic       prev_push = 1'b0;
    logic       prev_pop  = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_err  = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_exec   <= 1'b0;
            prev_hold <= 1'b0;
            prev_push <= 1'b0;
            prev_pop  <= 1'b0;
        end else begin
            chk("dual_strobe", 32'(stk_push && stk_pop), 0);
            chk("push_width", 32'(prev_push && stk_push), 0);
            chk("pop_width", 32'(prev_pop && stk_pop), 0);
            chk("ready_while_valid", 32'(cmd_ready && rsp_valid), 0);
            if (in_exec) begin
                if (exp_q.size() == 0) chk("exec_without_cmd", 1, 0);
                else begin
                    chk("exec_push", 32'(stk_push), 32'(exp_q[0].push));
                    chk("exec_pop", 32'(stk_pop), 32'(exp_q[0].pop));
                    chk("exec_select", 32'(stk_select), 32'(exp_q[0].sel));
                    chk("exec_data_in", 32'(stk_data_in), 32'(exp_q[0].data));
                end
            end else begin
                chk("idle_push", 32'(stk_push), 0);
                chk("idle_pop", 32'(stk_pop), 0);
                chk("idle_data_in", 32'(stk_data_in), 0);
            end
            if (prev_hold) begin
                chk("hold_valid", 32'(rsp_valid), 1);
                chk("hold_data", 32'(rsp_data), 32'(prev_data));
                chk("hold_err", 32'(rsp_err), 32'(prev_err));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) chk("rsp_without_cmd", 1, 0);
                else begin
                    chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].rdata));
                    chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
                    chk("err_count", 32'(err_count), 32'(exp_q[0].cnt));
                    exp_q.pop_front();
                end
            end
            in_exec   <= cmd_valid && cmd_ready;
            prev_hold <= rsp_valid && !rsp_ready;
            prev_data <= rsp_data;
            prev_err  <= rsp_err;
            prev_push <= stk_push;
            prev_pop  <= stk_pop;
        end
    end

    task automatic wait_accept(input logic [1:0] op, input logic sel, input logic [7:0] data, output bit ok);
        int n;
        cmd_op = op; cmd_sel = sel; cmd_data = data; cmd_valid = 1'b1; rsp_ready = 1'b0;
        ok = 1'b0; n = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
        else predict(op, sel, data);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic sel, input logic [7:0] data,
                           input int hold, input bit pulse,
                           output logic [7:0] rd, output logic re);
        bit ok;
        int n;
        rd = 8'h00; re = 1'b0;
        wait_accept(op, sel, data, ok);
        if (ok) begin
            n = 0;
            while (!rsp_valid && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            chk("rsp_latency", 32'(n), 1);
            for (int i = 0; i < hold; i++) begin
                if (pulse && i == 2) begin
                    cmd_valid = 1'b1; cmd_op = PUSH; cmd_sel = 1'b1; cmd_data = 8'hEE;
                end else begin
                    cmd_valid = 1'b0;
                end
                @(posedge clk); #1;
            end
            cmd_valid = 1'b0;
            rd = rsp_data; re = rsp_err; rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic       e;
        int         pc;
        bit         ok;

        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = NOP; cmd_sel = 1'b0; cmd_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_select", 32'(stk_select), 0);
        chk("rst_strobes", 32'({stk_push, stk_pop}), 0);
        chk("rst_data_in", 32'(stk_data_in), 0);
        @(posedge clk); #1;

        pc = push_cycles;
        run_cmd(PUSH, 1'b0, 8'hA5, 0, 0, d, e);
        chk("push_a5_err", 32'(e), 0);
        chk("push_a5_data", 32'(d), 0);
        chk("push_a5_one_strobe", 32'(push_cycles - pc), 1);
        chk("push_a5_stored", 32'(smem[0][0]), 32'h A5);

        run_cmd(PUSH, 1'b1, 8'h11, 0, 0, d, e);
        run_cmd(PUSH, 1'b1, 8'h22, 0, 0, d, e);
        run_cmd(POP, 1'b1, 8'h00, 0, 0, d, e);
        chk("lifo_first", 32'(d), 32'h22);
        run_cmd(POP, 1'b1, 8'h00, 0, 0, d, e);
        chk("lifo_second", 32'(d), 32'h11);
        run_cmd(POP, 1'b1, 8'h00, 0, 0, d, e);
        chk("underflow_err", 32'(e), 1);
        chk("underflow_data", 32'(d), 0);
        chk("underflow_count", 32'(err_count), 1);

        run_cmd(NOP, 1'b1, 8'h99, 0, 0, d, e);
        chk("nop_rsp", 32'({e, d}), 0);

        run_cmd(PUSH, 1'b0, 8'h3C, 0, 0, d, e);
        pc = pop_cycles;
        run_cmd(PEEK, 1'b0, 8'h00, 0, 0, d, e);
        chk("peek_data", 32'(d), 32'h3C);
        chk("peek_no_pop", 32'(pop_cycles - pc), 0);
        run_cmd(POP, 1'b0, 8'h00, 0, 0, d, e);
        chk("pop_after_peek", 32'(d), 32'h3C);
        run_cmd(POP, 1'b0, 8'h00, 0, 0, d, e);
        chk("pop_a5", 32'(d), 32'hA5);

        for (int i = 0; i < 16; i++) run_cmd(PUSH, 1'b0, 8'(8'h40 + i), 0, 0, d, e);
        pc = push_cycles;
        run_cmd(PUSH, 1'b0, 8'hFF, 0, 0, d, e);
        chk("overflow_err", 32'(e), 1);
        chk("overflow_no_push", 32'(push_cycles - pc), 0);
        chk("overflow_count", 32'(err_count), 2);
        run_cmd(PEEK, 1'b1, 8'h00, 0, 0, d, e);
        chk("peek_empty_s1_err", 32'(e), 1);
        chk("peek_empty_s1_count", 32'(err_count), 3);

        run_cmd(POP, 1'b0, 8'h00, 5, 1, d, e);
        chk("held_pop_data", 32'(d), 32'h4F);
        chk("held_pop_err", 32'(e), 0);
        chk("pulse_ignored", 32'(scnt[1]), 0);

        wait_accept(POP, 1'b0, 8'h00, ok);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete(); ref_s0.delete(); ref_s1.delete(); ref_err = 8'h00;
        @(negedge clk);
        chk("abort_cmd_ready", 32'(cmd_ready), 1);
        chk("abort_err_count", 32'(err_count), 0);
        chk("abort_stack_cleared", 32'(scnt[0]), 0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_rsp", 32'(rsp_valid), 0);
            @(negedge clk);
        end
        @(posedge clk); #1;

        run_cmd(PUSH, 1'b1, 8'h77, 0, 0, d, e);
        run_cmd(PEEK, 1'b1, 8'h00, 0, 0, d, e);
        chk("post_abort_peek", 32'(d), 32'h77);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
